// File: rtl/recop_led_pio_blink.sv
// Avalon-MM output PIO for the ReCOP LED bank: atomic set/clear, per-bit
// hardware blink with a programmable half-period, registered LED drive.
module recop_led_pio_blink #(
   parameter int unsigned          WIDTH        = 8,
   parameter logic [WIDTH-1:0]     RESET_VALUE  = '0,
   parameter int unsigned          PERIOD_W     = 24,
   parameter logic [PERIOD_W-1:0]  PERIOD_RESET = PERIOD_W'(12_500_000)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   typedef enum logic [2:0] {
      A_DATA      = 3'd0,
      A_RSVD1     = 3'd1,
      A_BLINK_EN  = 3'd2,
      A_BLINK_PER = 3'd3,
      A_OUTSET    = 3'd4,
      A_OUTCLEAR  = 3'd5,
      A_STATUS    = 3'd6,
      A_RSVD7     = 3'd7
   } reg_addr_e;

   localparam logic [PERIOD_W-1:0] CNT_RESET =
      (PERIOD_RESET == '0) ? '0 : PERIOD_RESET - PERIOD_W'(1);

   logic [WIDTH-1:0]    data_q,     data_d;
   logic [WIDTH-1:0]    blink_en_q, blink_en_d;
   logic [PERIOD_W-1:0] per_q,      per_d;
   logic [PERIOD_W-1:0] cnt_q,      cnt_d;
   logic                phase_q,    phase_d;
   logic [WIDTH-1:0]    out_q,      out_d;

   logic      wr;
   logic      per_wr;
   reg_addr_e addr;

   // Bits above the field widths are ignored by design.
   logic unused_wd;
   assign unused_wd = ^writedata;

   assign addr   = reg_addr_e'(address);
   assign wr     = chipselect & ~write_n;
   assign per_wr = wr && (addr == A_BLINK_PER);

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case statements can leave a latch behind.
   always_comb begin
      data_d     = data_q;
      blink_en_d = blink_en_q;
      per_d      = per_q;
      if (wr) begin
         case (addr)
            A_DATA:      data_d     = writedata[WIDTH-1:0];
            A_BLINK_EN:  blink_en_d = writedata[WIDTH-1:0];
            A_BLINK_PER: per_d      = writedata[PERIOD_W-1:0];
            A_OUTSET:    data_d     = data_q | writedata[WIDTH-1:0];
            A_OUTCLEAR:  data_d     = data_q & ~writedata[WIDTH-1:0];
            default:     ;
         endcase
      end
   end

   // A period write restarts the half-period from phase 0 and beats a
   // coincident terminal count.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (per_wr) begin
         cnt_d   = (per_d == '0) ? '0 : per_d - PERIOD_W'(1);
         phase_d = 1'b0;
      end else if (per_q == '0) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (cnt_q == '0) begin
         cnt_d   = per_q - PERIOD_W'(1);
         phase_d = ~phase_q;
      end else begin
         cnt_d   = cnt_q - PERIOD_W'(1);
      end
   end

   // LED drive lags the registers by one clock.
   always_comb begin
      out_d = data_q & ~(blink_en_q & {WIDTH{phase_q}});
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q     <= RESET_VALUE;
         blink_en_q <= '0;
         per_q      <= PERIOD_RESET;
         cnt_q      <= CNT_RESET;
         phase_q    <= 1'b0;
         out_q      <= RESET_VALUE;
      end else begin
         data_q     <= data_d;
         blink_en_q <= blink_en_d;
         per_q      <= per_d;
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
         out_q      <= out_d;
      end
   end

   assign out_port = out_q;

   always_comb begin
      readdata = '0;
      case (addr)
         A_DATA:      readdata = 32'(data_q);
         A_BLINK_EN:  readdata = 32'(blink_en_q);
         A_BLINK_PER: readdata = 32'(per_q);
         A_STATUS:    readdata = {31'b0, phase_q};
         default:     readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_recop_led_pio_blink.sv
// Bench for recop_led_pio_blink: directed register traffic against a model that
// derives blink phase from edges elapsed since the last period restart.
module tb_recop_led_pio_blink;

   localparam logic [23:0] PER_RST = 24'd6;

   logic        clk;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  out_port;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: registers plus the count of edges since the period epoch began.
   logic [7:0]  m_data = 8'h00;
   logic [7:0]  m_en   = 8'h00;
   logic [23:0] m_per  = PER_RST;
   int          m_k    = 0;
   logic [7:0]  m_out  = 8'h00;

   recop_led_pio_blink #(
      .WIDTH       (8),
      .RESET_VALUE (8'h00),
      .PERIOD_W    (24),
      .PERIOD_RESET(PER_RST)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .out_port  (out_port)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   function automatic logic model_phase(input int k, input logic [23:0] p);
      if (p == 24'd0) return 1'b0;
      return ((k / int'(p)) % 2) == 1;
   endfunction

   function automatic logic [31:0] model_rd(input logic [2:0] a);
      case (a)
         3'd0:    return {24'b0, m_data};
         3'd2:    return {24'b0, m_en};
         3'd3:    return {8'b0, m_per};
         3'd6:    return {31'b0, model_phase(m_k, m_per)};
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_data = 8'h00;
      m_en   = 8'h00;
      m_per  = PER_RST;
      m_k    = 0;
      m_out  = 8'h00;
   endtask

   // One bus cycle: drive, predict, take the edge, commit the prediction.
   task automatic cyc(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
      logic [7:0]  nd, ne, no;
      logic [23:0] np;
      int          nk;
      chipselect = cs;
      write_n    = wn;
      address    = a;
      writedata  = wd;
      no = m_data & ~(m_en & {8{model_phase(m_k, m_per)}});
      nd = m_data;
      ne = m_en;
      np = m_per;
      nk = m_k + 1;
      if (cs && !wn) begin
         case (a)
            3'd0: nd = wd[7:0];
            3'd2: ne = wd[7:0];
            3'd3: begin np = wd[23:0]; nk = 0; end
            3'd4: nd = m_data | wd[7:0];
            3'd5: nd = m_data & ~wd[7:0];
            default: ;
         endcase
      end
      @(posedge clk);
      m_data = nd;
      m_en   = ne;
      m_per  = np;
      m_k    = nk;
      m_out  = no;
      #1;
   endtask

   task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
      cyc(1'b0, 1'b1, a, 32'd0);
      check(name, readdata, exp);
   endtask

   always @(negedge clk) begin
      check("cyc_out_port", {24'b0, out_port}, {24'b0, m_out});
      check("cyc_readdata", readdata, model_rd(address));
   end

   initial begin
      reset_n    = 1'b0;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;

      // Reset state
      rd("rst_blink_per", 3'd3, 32'd6);
      rd("rst_status", 3'd6, 32'd0);
      check("rst_out_port", {24'b0, out_port}, 32'h0);

      // DATA write and one-cycle LED lag; deselected writes ignored
      cyc(1'b1, 1'b0, 3'd0, 32'h0000_00A5);
      check("data_rd_after_write", readdata, 32'hA5);
      check("out_lag_same_edge", {24'b0, out_port}, 32'h0);
      cyc(1'b0, 1'b1, 3'd0, 32'd0);
      check("out_next_edge", {24'b0, out_port}, 32'hA5);
      cyc(1'b0, 1'b0, 3'd0, 32'h0000_0011);
      check("cs0_ignored", readdata, 32'hA5);
      cyc(1'b1, 1'b1, 3'd0, 32'h0000_0022);
      check("wn1_ignored", readdata, 32'hA5);

      // Atomic set/clear and write-ignored addresses
      cyc(1'b1, 1'b0, 3'd0, 32'h0000_00A0);
      cyc(1'b1, 1'b0, 3'd4, 32'h0000_000F);
      rd("outset_data", 3'd0, 32'hAF);
      cyc(1'b1, 1'b0, 3'd5, 32'h0000_0081);
      rd("outclear_data", 3'd0, 32'h2E);
      rd("outset_reads0", 3'd4, 32'd0);
      rd("outclear_reads0", 3'd5, 32'd0);
      cyc(1'b1, 1'b0, 3'd1, 32'hFFFF_FFFF);
      cyc(1'b1, 1'b0, 3'd7, 32'hFFFF_FFFF);
      rd("rsvd_reads0", 3'd1, 32'd0);
      rd("rsvd_no_side_effect", 3'd0, 32'h2E);

      // Blink bit0 with a half-period of 4
      cyc(1'b1, 1'b0, 3'd0, 32'h0000_00FF);
      cyc(1'b1, 1'b0, 3'd2, 32'h0000_0001);
      cyc(1'b1, 1'b0, 3'd3, 32'd4);
      for (int j = 1; j <= 16; j++) begin
         cyc(1'b0, 1'b1, 3'd6, 32'd0);
         check("blink_out", {24'b0, out_port}, (((j - 1) / 4) % 2 == 1) ? 32'hFE : 32'hFF);
         check("blink_status", readdata, 32'((j / 4) % 2));
      end

      // Mid-blink period write of 0 parks phase at 0
      repeat (4) cyc(1'b0, 1'b1, 3'd6, 32'd0);
      check("phase1_before_stop", readdata, 32'd1);
      cyc(1'b1, 1'b0, 3'd3, 32'd0);
      check("per0_readback", readdata, 32'd0);
      check("per0_out_lag", {24'b0, out_port}, 32'hFE);
      for (int j = 0; j < 5; j++) begin
         cyc(1'b0, 1'b1, 3'd6, 32'd0);
         check("per0_out_steady", {24'b0, out_port}, 32'hFF);
         check("per0_status", readdata, 32'd0);
      end

      // Period write on the terminal-count edge: reload, no toggle
      cyc(1'b1, 1'b0, 3'd3, 32'd4);
      repeat (3) cyc(1'b0, 1'b1, 3'd6, 32'd0);
      cyc(1'b1, 1'b0, 3'd3, 32'd3);
      check("tc_per_readback", readdata, 32'd3);
      for (int j = 1; j <= 4; j++) begin
         cyc(1'b0, 1'b1, 3'd6, 32'd0);
         check("tc_status", readdata, (j >= 3) ? 32'd1 : 32'd0);
         check("tc_out", {24'b0, out_port}, (j == 4) ? 32'hFE : 32'hFF);
      end

      // Asynchronous reset mid-blink, no clock edge in between
      reset_n = 1'b0;
      model_reset();
      #1;
      check("async_rst_out", {24'b0, out_port}, 32'h0);
      check("async_rst_status", readdata, 32'd0);
      address = 3'd0;
      #1 check("async_rst_data", readdata, 32'd0);
      address = 3'd2;
      #1 check("async_rst_blink_en", readdata, 32'd0);
      address = 3'd3;
      #1 check("async_rst_blink_per", readdata, 32'd6);
      #1 reset_n = 1'b1;

      // Over-wide write data truncates; counting restarts from PERIOD_RESET-1
      cyc(1'b1, 1'b0, 3'd0, 32'hFFFF_FFFF);
      check("wide_write_data", readdata, 32'h0000_00FF);
      check("wide_write_out_lag", {24'b0, out_port}, 32'h0);
      for (int j = 2; j <= 8; j++) begin
         cyc(1'b0, 1'b1, 3'd6, 32'd0);
         check("restart_status", readdata, 32'((j / 6) % 2));
         check("restart_out", {24'b0, out_port}, 32'hFF);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
